idma_wr_desc_gen: RTL
=====================

# idma_wr_desc_gen

Write-side 2D descriptor walker for the iDMA. It accepts one 2D transfer command (base address, words per row, row count, row stride) and breaks it into one (address, word-count) entry per row. Entries are buffered in an internal FIFO that presents the `waddr_fifo_*` interface consumed by `axi_wr_if`. The block sits directly upstream of that interface, between the cfg register block and the AXI write path.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entry buffer depth; power of 2, ≥2.
- `WORD_BYTES`, 32: bytes per word; equals AXI_DATA_WID/8. Informational only; the stride is already in bytes.

Ports:
- `aclk`  in  1  clock.
- `areset`  in  1  reset, synchronous, active-high.
- `cfg_start`  in  1  one-cycle pulse that launches a command; ignored unless the block is idle.
- `cfg_abort`  in  1  flushes the FIFO and returns to idle.
- `cfg_base_addr`  in  32  byte address of row 0.
- `cfg_row_words`  in  16  words per row.
- `cfg_row_num`  in  16  number of rows.
- `cfg_row_stride`  in  32  byte distance between row start addresses.
- `waddr_fifo_waddr_in`  out  32  head-entry address.
- `waddr_fifo_wr_num_word`  out  32  head-entry word count; `{16'b0, row_words}`.
- `waddr_fifo_empty`  out  1  FIFO empty.
- `waddr_fifo_pop`  in  1  consumer pop of the head entry.
- `busy`  out  1  high from the start edge until done or abort.
- `done`  out  1  one-cycle pulse when every entry has been generated and popped.

## Operation
- Command fields are sampled on the `cfg_start` edge into internal registers: `cur_addr`, `rows_left`, `row_words`, `stride`. Later changes to the `cfg_*` inputs have no effect.
- FSM states are IDLE, GEN, DRAIN, DONE.
  - IDLE → GEN on `cfg_start` when `cfg_row_num != 0` and `cfg_row_words != 0`.
  - IDLE → DONE on `cfg_start` when either field is 0. No entries are generated.
  - In GEN, each cycle with `count != FIFO_DEPTH`, the block pushes `{cur_addr, row_words}`, sets `cur_addr += stride`, and sets `rows_left -= 1`.
  - GEN → DRAIN on the push that makes `rows_left` 0.
  - DRAIN → DONE when the FIFO is empty.
  - DONE → IDLE unconditionally. `done` is high in DONE only.
- Push has no same-cycle bypass: a push requires `count < FIFO_DEPTH` as registered, even if a pop occurs in the same cycle.
- Address arithmetic is modulo 2^32, so the address wraps silently. The block does no 4 KB splitting; that is the downstream cross-4K stage's job.
- FIFO:
  - Read and write pointers carry a wrap bit; `count` is derived from the pointers.
  - Simultaneous push and pop in the same cycle leaves `count` unchanged.
  - A pop while empty is ignored, with no pointer change.
  - The head outputs are read combinationally from the storage array at `rd_ptr`; they are valid only while `!waddr_fifo_empty`.
- `cfg_abort`, in any state:
  - Next cycle: pointers are reset, `waddr_fifo_empty` = 1, state = IDLE, `busy` = 0.
  - No `done` pulse is produced.
  - Abort has priority over start and pop in the same cycle.
- `cfg_start` received while `busy` is ignored, with no effect on the registered fields.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `waddr_fifo_empty` 1, `waddr_fifo_waddr_in` 0, `waddr_fifo_wr_num_word` 0, pointers 0. Storage is cleared to 0 on reset.
- `cfg_start` at edge T:
  - State is GEN from T+1.
  - The first push happens at edge T+1.
  - `waddr_fifo_empty` falls in cycle T+2, with the head entry valid in that cycle.
- With no back-pressure, throughput is 1 entry per cycle. The FIFO fills after `FIFO_DEPTH` pushes; after that, each pop frees one slot and the next push follows one cycle later.
- `busy` rises at T+1 and falls in the cycle after DONE. `done` asserts exactly one cycle after the last pop retires (DRAIN sees empty).
- Zero-length command: `done` pulses at T+1 and `busy` is never high.

## Test plan
- **Basic 2D run.** base=0x1000_0000, words=4, rows=3, stride=0x200, `waddr_fifo_pop` held at 1 → entries (0x10000000,4), (0x10000200,4), (0x10000400,4) in consecutive cycles. `done` pulses once and `busy` drops.
- **Back-pressure.** rows=6, DEPTH=4, pop held 0 for 10 cycles → exactly 4 entries buffered, `busy`=1. When pops resume, the remaining 2 entries arrive in order and `done` follows the sixth pop.
- **Zero length.** rows=0 (and separately words=0) → `waddr_fifo_empty` stays 1, `done` pulses at T+1, no entries.
- **Address wrap.** base=0xFFFF_FF00, stride=0x100, rows=2 → addresses 0xFFFFFF00 then 0x00000000.
- **Abort mid-run.** rows=8, pop=0, `cfg_abort` after 3 pushes → next cycle empty=1, `busy`=0, no `done`. A new `cfg_start` then runs normally from row 0.
- **Start ignored while busy; pop on empty.** A second `cfg_start` with different fields during GEN produces no change in the entry stream. Pops while empty leave the pointers unchanged, and `count` never underflows.

Source files
------------

// File: rtl/idma_wr_desc_gen.sv
// Write-side 2D descriptor walker: splits one (base, words, rows, stride) command into per-row (addr, words) FIFO entries.
// Latency: first entry visible two cycles after the cfg_start edge; one entry per cycle when the consumer keeps up.
// Backpressure: generation stalls while the FIFO is full (registered count, no push/pop bypass); cfg_abort flushes.
module idma_wr_desc_gen #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_BYTES = 32
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        cfg_start,
    input  logic        cfg_abort,
    input  logic [31:0] cfg_base_addr,
    input  logic [15:0] cfg_row_words,
    input  logic [15:0] cfg_row_num,
    input  logic [31:0] cfg_row_stride,
    output logic [31:0] waddr_fifo_waddr_in,
    output logic [31:0] waddr_fifo_wr_num_word,
    output logic        waddr_fifo_empty,
    input  logic        waddr_fifo_pop,
    output logic        busy,
    output logic        done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    // Reject parameter sets the pointer arithmetic cannot support.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WORD_BYTES < 1) begin : g_bad_params
        $error("idma_wr_desc_gen: FIFO_DEPTH must be a power of 2 >= 2 and WORD_BYTES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GEN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Command registers captured on an accepted start.
    logic [31:0] cur_addr_q;
    logic [15:0] rows_left_q;
    logic [15:0] row_words_q;
    logic [31:0] stride_q;
    logic        zero_cmd_q;

    // Entry FIFO: pointers carry a wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    logic [PTR_W:0] count;
    logic [31:0]    mem_addr_q  [FIFO_DEPTH];
    logic [15:0]    mem_words_q [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic start_ok;
    logic cmd_zero;
    logic last_push;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (count == DEPTH_CNT);

    // Start is only honoured in IDLE and loses to a concurrent abort.
    assign start_ok  = (state_q == S_IDLE) && cfg_start && !cfg_abort;
    assign cmd_zero  = (cfg_row_num == 16'd0) || (cfg_row_words == 16'd0);
    // Pops on an empty FIFO are dropped so the read pointer never passes the write pointer.
    assign pop       = waddr_fifo_pop && !fifo_empty && !cfg_abort;
    assign last_push = push && (rows_left_q == 16'd1);

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (cfg_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_d = cmd_zero ? S_DONE : S_GEN;
                    end
                end
                S_GEN: begin
                    if (last_push) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from state; a zero-length command pulses done without ever raising busy.
    always_comb begin
        push = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_GEN: begin
                push = !fifo_full && !cfg_abort;
                busy = 1'b1;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = !zero_cmd_q;
                done = 1'b1;
            end
            default: begin
                push = 1'b0;
            end
        endcase
    end

    // Command capture and per-row address/row-count advance.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cur_addr_q  <= 32'd0;
            rows_left_q <= 16'd0;
            row_words_q <= 16'd0;
            stride_q    <= 32'd0;
            zero_cmd_q  <= 1'b0;
        end else if (start_ok) begin
            cur_addr_q  <= cfg_base_addr;
            rows_left_q <= cfg_row_num;
            row_words_q <= cfg_row_words;
            stride_q    <= cfg_row_stride;
            zero_cmd_q  <= cmd_zero;
        end else if (push) begin
            // Wraps modulo 2^32; 4 KB splitting happens downstream.
            cur_addr_q  <= cur_addr_q + stride_q;
            rows_left_q <= rows_left_q - 16'd1;
        end
    end

    // FIFO pointers; abort flushes by collapsing both pointers to zero.
    always_ff @(posedge aclk) begin
        if (areset || cfg_abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Entry storage, cleared on reset so the head reads zero out of reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_addr_q[i]  <= 32'd0;
                mem_words_q[i] <= 16'd0;
            end
        end else if (push) begin
            mem_addr_q[wr_ptr_q[PTR_W-1:0]]  <= cur_addr_q;
            mem_words_q[wr_ptr_q[PTR_W-1:0]] <= row_words_q;
        end
    end

    assign waddr_fifo_waddr_in    = mem_addr_q[rd_ptr_q[PTR_W-1:0]];
    assign waddr_fifo_wr_num_word = {16'b0, mem_words_q[rd_ptr_q[PTR_W-1:0]]};
    assign waddr_fifo_empty       = fifo_empty;

endmodule
